// File: rtl/switch_input_pkg.sv
// Shared definitions for the switch input block: FSM encoding, switch layout
// and the default debounce length (10 ms at 50 MHz).
package switch_input_pkg;

  localparam int SW_W                 = 18;
  localparam int VAL_W                = 17;
  localparam int COMMIT_BIT           = 17;
  localparam int DEBOUNCE_CYCLES_DEF  = 500000;

  // IDLE encodes as zero so a cleared state register is IDLE.
  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    WAIT_CLEAR   = 3'd1,
    ARMED        = 3'd2,
    WAIT_RELEASE = 3'd3,
    DONE         = 3'd4
  } state_e;

endpackage

// File: rtl/switch_input_debounce.sv
// Level debouncer: the output follows the input only after the input has
// differed from the output for CYCLES consecutive clocks. Any return to the
// current output level restarts the count. Reusable for KEY inputs.
module debounce
  import switch_input_pkg::*;
#(
  parameter int CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic in,
  output logic out
);

  localparam int               CNT_W    = $clog2(CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;

  // Count consecutive disagreeing cycles; flip the output on the last one.
  // The count stops at CNT_LAST, so it can never wrap.
  always_comb begin
    cnt_d = cnt_q;
    out_d = out_q;
    if (in == out_q) begin
      cnt_d = '0;
    end else if (cnt_q >= CNT_LAST) begin
      out_d = in;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers with synchronous clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
      out_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: rtl/switch_input.sv
// Switch input block: synchronizes the board switches, debounces the commit
// switch and hands a committed 17-bit value to the processor through a
// req / valid handshake. A live synchronized copy drives the display path.
module switch_input
  import switch_input_pkg::*;
#(
  parameter int WORD_WIDTH      = 32,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [SW_W-1:0]       SW,
  input  logic                  req,
  output logic [WORD_WIDTH-1:0] data,
  output logic                  valid,
  output logic                  busy,
  output logic [VAL_W-1:0]      preview,
  output logic                  preview_nz
);

  logic [SW_W-1:0]       sw_s1_q, sw_s2_q;
  logic                  preview_nz_q;
  logic                  commit_db;
  state_e                state_q;
  logic [WORD_WIDTH-1:0] data_q;
  logic                  valid_q;
  logic                  busy_q;

  // Two-flop synchronizer for every switch bit. The non-zero flag is taken
  // from the first stage so it lines up with the second-stage preview.
  always_ff @(posedge clock) begin
    if (reset) begin
      sw_s1_q      <= '0;
      sw_s2_q      <= '0;
      preview_nz_q <= 1'b0;
    end else begin
      sw_s1_q      <= SW;
      sw_s2_q      <= sw_s1_q;
      preview_nz_q <= |sw_s1_q[VAL_W-1:0];
    end
  end

  debounce #(
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_commit_db (
    .clock (clock),
    .reset (reset),
    .in    (sw_s2_q[COMMIT_BIT]),
    .out   (commit_db)
  );

  // Handshake FSM with registered data/valid/busy. A commit that is already
  // on when the request arrives must be released first (WAIT_CLEAR), so a
  // stale switch position is never taken as a fresh commit. Once a value is
  // captured the sequence always completes, even if req drops.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            state_q <= commit_db ? WAIT_CLEAR : ARMED;
            busy_q  <= 1'b1;
          end else begin
            busy_q  <= 1'b0;
          end
        end
        WAIT_CLEAR: begin
          if (!req) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (!commit_db) begin
            state_q <= ARMED;
          end
        end
        ARMED: begin
          if (!req) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (commit_db) begin
            data_q  <= WORD_WIDTH'(sw_s2_q[VAL_W-1:0]);
            state_q <= WAIT_RELEASE;
          end
        end
        WAIT_RELEASE: begin
          if (!commit_db) begin
            state_q <= DONE;
            valid_q <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data       = data_q;
  assign valid      = valid_q;
  assign busy       = busy_q;
  assign preview    = sw_s2_q[VAL_W-1:0];
  assign preview_nz = preview_nz_q;

endmodule

// File: tb/tb_switch_input.sv
// Directed bench for switch_input with a short debounce (4 cycles).
// Expected committed words are queued when stimulus is driven and popped
// when the DUT pulses valid.
module tb_switch_input;

  logic        clock;
  logic        reset;
  logic [17:0] SW;
  logic        req;
  logic [31:0] data;
  logic        valid;
  logic        busy;
  logic [16:0] preview;
  logic        preview_nz;

  int          n_assert;
  int          n_fail;
  int          pulses;
  int          dbl;
  logic        prev_valid;
  logic [31:0] exp_q[$];

  switch_input #(
    .WORD_WIDTH      (32),
    .DEBOUNCE_CYCLES (4)
  ) u_dut (
    .clock      (clock),
    .reset      (reset),
    .SW         (SW),
    .req        (req),
    .data       (data),
    .valid      (valid),
    .busy       (busy),
    .preview    (preview),
    .preview_nz (preview_nz)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Count valid pulses and back-to-back valid cycles.
  initial begin
    pulses     = 0;
    dbl        = 0;
    prev_valid = 1'b0;
  end
  always @(negedge clock) begin
    if (valid === 1'b1) pulses = pulses + 1;
    if (valid === 1'b1 && prev_valid === 1'b1) dbl = dbl + 1;
    prev_valid = valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Wait (bounded) for a valid pulse, then compare data with the scoreboard.
  task automatic wait_valid(input string tag);
    bit          seen;
    logic [31:0] e;
    seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clock);
      if (valid === 1'b1) seen = 1'b1;
    end
    check({tag, "_seen"}, 32'(seen), 32'd1);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = 32'hDEAD_BEEF;
    check(tag, data, e);
  endtask

  task automatic set_sw(input logic commit, input logic [16:0] val);
    SW = {commit, val};
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    reset    = 1'b1;
    req      = 1'b0;
    SW       = 18'h0;
    step(3);

    // Reset state.
    check("rst_data", data, 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_preview", 32'(preview), 32'h0);
    check("rst_preview_nz", 32'(preview_nz), 32'h0);
    reset = 1'b0;
    step(2);

    // Basic commit.
    set_sw(1'b0, 17'h00A5);
    req = 1'b1;
    step(2);
    check("basic_busy", 32'(busy), 32'h1);
    exp_q.push_back(32'h0000_00A5);
    set_sw(1'b1, 17'h00A5);
    step(10);
    set_sw(1'b0, 17'h00A5);
    wait_valid("basic_data");
    @(negedge clock);
    check("basic_busy_after", 32'(busy), 32'h0);
    step(1);
    req = 1'b0;
    step(5);
    check("basic_pulses", 32'(pulses), 32'd1);

    // Stale commit: already on when req rises.
    set_sw(1'b1, 17'h0111);
    step(10);
    req = 1'b1;
    step(10);
    check("stale_busy", 32'(busy), 32'h1);
    check("stale_no_valid", 32'(pulses), 32'd1);
    set_sw(1'b0, 17'h0111);
    step(10);
    check("stale_still_none", 32'(pulses), 32'd1);
    set_sw(1'b1, 17'h0B0B);
    exp_q.push_back(32'h0000_0B0B);
    step(10);
    set_sw(1'b0, 17'h0B0B);
    wait_valid("stale_data");
    step(1);
    req = 1'b0;
    step(5);

    // Glitch rejection: 3-cycle pulses never reach 4 stable cycles.
    req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_sw(1'b1, 17'h0055);
      step(3);
      set_sw(1'b0, 17'h0055);
      step(3);
    end
    step(10);
    check("glitch_db", 32'(u_dut.commit_db), 32'h0);
    check("glitch_pulses", 32'(pulses), 32'd2);
    check("glitch_busy", 32'(busy), 32'h1);

    // Cancel in ARMED.
    req = 1'b0;
    step(3);
    check("cancel_busy", 32'(busy), 32'h0);
    check("cancel_data", data, 32'h0000_0B0B);
    check("cancel_pulses", 32'(pulses), 32'd2);

    // Late drop in WAIT_RELEASE still completes.
    req = 1'b1;
    set_sw(1'b1, 17'h1234);
    exp_q.push_back(32'h0000_1234);
    step(9);
    req = 1'b0;
    set_sw(1'b0, 17'h1234);
    wait_valid("late_drop_data");
    step(5);

    // Reset in WAIT_RELEASE aborts without a pulse.
    req = 1'b1;
    set_sw(1'b1, 17'h0777);
    step(9);
    check("midrst_busy_pre", 32'(busy), 32'h1);
    reset = 1'b1;
    req   = 1'b0;
    set_sw(1'b0, 17'h0777);
    step(1);
    check("midrst_data", data, 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_valid", 32'(valid), 32'h0);
    check("midrst_preview", 32'(preview), 32'h0);
    reset = 1'b0;
    step(10);
    check("midrst_pulses", 32'(pulses), 32'd3);
    set_sw(1'b0, 17'h0C3C);
    req = 1'b1;
    step(2);
    set_sw(1'b1, 17'h0C3C);
    exp_q.push_back(32'h0000_0C3C);
    step(10);
    set_sw(1'b0, 17'h0C3C);
    wait_valid("post_rst_data");
    step(1);
    req = 1'b0;
    step(5);

    // Capture point and preview latency.
    req = 1'b1;
    set_sw(1'b1, 17'h1FFFF);
    exp_q.push_back(32'h0001_FFFF);
    step(9);
    check("cap_preview", 32'(preview), 32'h0001_FFFF);
    check("cap_preview_nz", 32'(preview_nz), 32'h1);
    set_sw(1'b1, 17'h0);
    step(1);
    check("cap_nz_lat1", 32'(preview_nz), 32'h1);
    step(1);
    check("cap_nz_lat2", 32'(preview_nz), 32'h0);
    check("cap_preview_zero", 32'(preview), 32'h0);
    set_sw(1'b0, 17'h0);
    wait_valid("cap_data");
    step(1);
    req = 1'b0;
    step(5);

    check("total_pulses", 32'(pulses), 32'd5);
    check("no_double_valid", 32'(dbl), 32'd0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/switch_input.md
SWITCH_INPUT -- requirements
Module: switch_input

Interface
REQ-001 Parameter: WORD_WIDTH, default 32, width of the delivered data word (matches the processor word).
REQ-002 Parameter: DEBOUNCE_CYCLES, default 500000, consecutive stable cycles needed to accept a commit change (10 ms at 50 MHz); legal range is 1 or more.
REQ-003 Port: clock  in  1  single clock for all logic.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Port: SW  in  18  raw board switches; SW[16:0] are the value and SW[17] is the commit switch.
REQ-006 Port: req  in  1  level request from the processor, held while the processor is waiting on an input read.
REQ-007 Port: data  out  WORD_WIDTH  last committed value, SW[16:0] zero-extended.
REQ-008 Port: valid  out  1  one-cycle pulse marking `data` as a new committed value.
REQ-009 Port: busy  out  1  high while a request is being serviced (state not IDLE).
REQ-010 Port: preview  out  17  synchronized live SW[16:0], for the display path.
REQ-011 Port: preview_nz  out  1  high when `preview` is non-zero.

Function
REQ-012 All SW bits SHALL pass through a two-flop synchronizer before any use.
REQ-013 The synchronized SW[17] SHALL be debounced: `commit_db` changes only after the synchronized input differs from `commit_db` for DEBOUNCE_CYCLES consecutive cycles, and any glitch restarts the count.
REQ-014 The FSM SHALL have states IDLE, WAIT_CLEAR, ARMED, WAIT_RELEASE and DONE.
REQ-015 IDLE: when req=1, go to WAIT_CLEAR if commit_db=1, otherwise go to ARMED.
REQ-016 WAIT_CLEAR: go to ARMED when commit_db=0; a commit that was already on when the request arrived is never accepted.
REQ-017 ARMED: in the cycle commit_db rises, `data` SHALL load the synchronized SW[16:0] zero-extended, and the FSM goes to WAIT_RELEASE.
REQ-018 WAIT_RELEASE: go to DONE when commit_db falls.
REQ-019 DONE: valid=1 for exactly this one cycle, then return to IDLE.
REQ-020 If req drops in WAIT_CLEAR or ARMED, return to IDLE next cycle with no valid pulse and `data` unchanged.
REQ-021 If req drops in WAIT_RELEASE, the sequence SHALL still complete; valid pulses and `data` holds the captured value.
REQ-022 `data` SHALL hold its value between captures.
REQ-023 valid SHALL never be high for two consecutive cycles.
REQ-024 preview and preview_nz SHALL update every cycle, independent of FSM state.
REQ-025 The debounce counter SHALL saturate and never wrap; its width is clog2(DEBOUNCE_CYCLES+1).
REQ-026 Value-switch changes after the capture cycle SHALL NOT affect `data`.

Reset
REQ-027 When reset=1 at a clock edge, the following SHALL clear to zero: FSM (to IDLE), data, valid, busy, preview, preview_nz, synchronizer flops, commit_db and the debounce counter.
REQ-028 Reset mid-sequence SHALL abort without a valid pulse; after reset, a commit switch that is still high is treated as 1 only after debounce, and via REQ-015 it is then routed through WAIT_CLEAR.

Structure
REQ-029 The FSM state encoding and the default DEBOUNCE_CYCLES SHALL live in the shared global include, alongside the existing word/arg width macros.
REQ-030 The debouncer SHALL be a sub-module `debounce` (parameter CYCLES; ports clock, reset, in, out) so it can be reused for KEY inputs.
REQ-031 The block SHALL replace the processor's direct sampling of SW: the processor drives req in its switch-read deference state and resumes on valid.

Verification (DEBOUNCE_CYCLES=4)
REQ-032 Basic commit: SW[16:0]=0x00A5, req=1, SW[17] high for 10 cycles then low for 10 cycles -> exactly one valid pulse with data=0x000000A5; busy falls the cycle after the pulse.
REQ-033 Stale commit: SW[17]=1 before req rises -> no valid until SW[17] has gone low, high and low again; the captured value is the one present at the second rise.
REQ-034 Glitch rejection: SW[17] pulses high for 3 cycles, repeated 5 times with 3-cycle low gaps -> commit_db stays 0 and no valid.
REQ-035 Cancel and late drop: req drops in ARMED -> IDLE, no valid, data retains the prior value; req drops in WAIT_RELEASE -> valid still pulses once.
REQ-036 Reset mid-sequence: reset asserted in WAIT_RELEASE -> all outputs 0 the next cycle, no valid; a new request after reset captures a fresh value.
REQ-037 Capture point and preview: SW[16:0]=0x1FFFF at the commit rise, then changed to 0 during WAIT_RELEASE -> data=0x0001FFFF; preview_nz follows the live switches with 2-cycle latency.
